sync_fifo: RTL and testbench

Single-clock synchronous FIFO buffering fixed-width data words between a producer and a consumer in the same clock domain. Default configuration is 16 entries of 16 bits. It has write/read strobes with full/empty status flags and a registered read-data output. Internal read pointer, write pointer and occupancy count are exposed as named internal signals (rd_ptr, wr_ptr, cnt) so bound assertion modules can observe them.

---
 rtl/sync_fifo.sv | 78 +++++++
 tb/tb_sync_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Pointers and occupancy (rd_ptr, wr_ptr, cnt) are kept as plainly named
// internal signals so bound assertion modules can observe them.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_en;
  logic                  rd_en;

  // Flags are a pure decode of the occupancy count.
  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);

  // Requests are qualified against the flags as they stand before the edge.
  assign wr_en = fifo_write & ~fifo_full;
  assign rd_en = fifo_read  & ~fifo_empty;

  // Storage: not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_ && wr_en) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  // Write pointer advances on each accepted write, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and registered output; output holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      rd_ptr        <= '0;
      fifo_data_out <= '0;
    end else if (rd_en) begin
      rd_ptr        <= rd_ptr + PTR_ONE;
      fifo_data_out <= mem[rd_ptr];
    end
  end

  // Occupancy: up on write only, down on read only, unchanged otherwise.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test plan plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the FIFO.
module tb_sync_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_write;
  logic          fifo_read;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_full;
  logic          fifo_empty;

  int n_assert = 0;
  int n_fail   = 0;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .fifo_data_in(fifo_data_in),
    .fifo_write(fifo_write),
    .fifo_read(fifo_read),
    .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words, counts of accepted
  // writes/reads modulo DEPTH, and the last word delivered.
  int          m_q[$];
  logic [DW-1:0] m_dout;
  int          m_rp;
  int          m_wp;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    bit can_w;
    bit can_r;
    if (!rst_) begin
      m_q.delete();
      m_dout  = '0;
      m_rp    = 0;
      m_wp    = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      can_w = fifo_write && (m_q.size() < DEPTH);
      can_r = fifo_read && (m_q.size() > 0);
      if (can_r) begin
        m_dout = DW'(m_q.pop_front());
        m_rp   = (m_rp + 1) % DEPTH;
      end
      if (can_w) begin
        m_q.push_back(int'(fifo_data_in));
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
  end

  // Per-cycle comparison of every observable against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("data_out", 32'(fifo_data_out), 32'(m_dout));
      chk("full",     32'(fifo_full),  32'(m_q.size() == DEPTH));
      chk("empty",    32'(fifo_empty), 32'(m_q.size() == 0));
      chk("cnt",      32'(dut.cnt),    32'(m_q.size()));
      chk("rd_ptr",   32'(dut.rd_ptr), 32'(m_rp));
      chk("wr_ptr",   32'(dut.wr_ptr), 32'(m_wp));
    end
  end

  // Apply one cycle of inputs at a falling edge and advance to the next one.
  task automatic tick(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst_         = r;
    fifo_write   = w;
    fifo_read    = rd;
    fifo_data_in = d;
    @(negedge clk);
  endtask

  initial begin
    int wprob;
    int rprob;
    rst_ = 1'b0;
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    fifo_data_in = '0;
    @(negedge clk);

    // 1. Reset
    repeat (4) tick(1'b0, 1'b0, 1'b0, '0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full",  32'(fifo_full), 32'd0);
    chk("rst_dout",  32'(fifo_data_out), 32'd0);
    chk("rst_cnt",   32'(dut.cnt), 32'd0);
    chk("rst_ptrs",  32'({dut.rd_ptr, dut.wr_ptr}), 32'd0);

    // 2. Fill with 1..16
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b1, 1'b1, 1'b0, DW'(i));
      chk("fill_cnt", 32'(dut.cnt), 32'(i));
      chk("fill_empty", 32'(fifo_empty), 32'd0);
      chk("fill_full", 32'(fifo_full), 32'(i == DEPTH));
    end
    chk("fill_wr_wrap", 32'(dut.wr_ptr), 32'd0);
    chk("model_fill_size", 32'(m_q.size()), 32'd16);

    // 3. Overflow
    tick(1'b1, 1'b1, 1'b0, DW'(234));
    chk("ovf_cnt", 32'(dut.cnt), 32'd16);
    chk("ovf_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("model_ovf_tail", 32'(m_q[DEPTH-1]), 32'd16);

    // 4. Drain: expect 1..16 in order
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b1, 1'b0, 1'b1, '0);
      chk("drain_dout", 32'(fifo_data_out), 32'(i));
      chk("drain_full", 32'(fifo_full), 32'd0);
      chk("drain_empty", 32'(fifo_empty), 32'(i == DEPTH));
    end
    chk("drain_rd_wrap", 32'(dut.rd_ptr), 32'd0);

    // 5. Underflow
    repeat (4) tick(1'b1, 1'b0, 1'b1, '0);
    chk("udf_dout", 32'(fifo_data_out), 32'd16);
    chk("udf_cnt", 32'(dut.cnt), 32'd0);
    chk("udf_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    chk("udf_empty", 32'(fifo_empty), 32'd1);
    chk("model_udf_dout", 32'(m_dout), 32'd16);

    // 6a. Empty, read+write: only the write lands
    tick(1'b1, 1'b1, 1'b1, 16'hAAAA);
    chk("sim_empty_cnt", 32'(dut.cnt), 32'd1);
    chk("sim_empty_dout", 32'(fifo_data_out), 32'd16);

    // 6b. Occupancy 5, read+write: count holds, both pointers move
    for (int i = 2; i <= 5; i++) tick(1'b1, 1'b1, 1'b0, DW'(i));
    chk("pre5_cnt", 32'(dut.cnt), 32'd5);
    tick(1'b1, 1'b1, 1'b1, 16'h1006);
    chk("sim5_cnt", 32'(dut.cnt), 32'd5);
    chk("sim5_rd_ptr", 32'(dut.rd_ptr), 32'd1);
    chk("sim5_wr_ptr", 32'(dut.wr_ptr), 32'd6);
    chk("sim5_dout", 32'(fifo_data_out), 32'hAAAA);

    // 6c. Full, read+write: read only, write dropped
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b1, 1'b0, DW'(16'h2000 + i));
    chk("prefull_cnt", 32'(dut.cnt), 32'd16);
    tick(1'b1, 1'b1, 1'b1, 16'hBEEF);
    chk("simfull_cnt", 32'(dut.cnt), 32'd15);
    chk("simfull_dout", 32'(fifo_data_out), 32'd2);
    chk("simfull_wr_ptr", 32'(dut.wr_ptr), 32'd1);
    chk("simfull_rd_ptr", 32'(dut.rd_ptr), 32'd2);
    chk("model_simfull_tail", 32'(m_q[m_q.size()-1]), 32'h200A);

    // 6d. Mid-run reset
    tick(1'b0, 1'b1, 1'b1, 16'h5555);
    chk("midrst_cnt", 32'(dut.cnt), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_dout", 32'(fifo_data_out), 32'd0);

    // Randomized traffic in phases biased towards filling, draining, or balance
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0: begin wprob = 80; rprob = 30; end
        1: begin wprob = 30; rprob = 80; end
        default: begin wprob = 60; rprob = 60; end
      endcase
      for (int c = 0; c < 200; c++) begin
        tick(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 99) < wprob),
             ($urandom_range(0, 99) < rprob),
             DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
